jt7759_nbuf: RTL

Nibble buffer between the jt7759 control/ROM-fetch logic and the ADPCM decoder. Accepts ADPCM bytes from the control side through a valid/ready handshake, stores them in a small FIFO and delivers one 4-bit nibble per decoder clock-enable pulse (`cen_dec` from the clock divider), high nibble first. It flags decoder starvation so the control logic can detect ROM-fetch underruns.

---
 rtl/jt7759_nbuf.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/jt7759_nbuf.sv
// Nibble buffer between jt7759 ROM-fetch control and the ADPCM decoder: byte FIFO in, one nibble per cen_dec out.
// Optional underflow event counter output ufcnt enabled by defining JT7759_NBUF_UFCNT_EN.
module jt7759_nbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          cen_dec,
  input  logic          flush,
  input  logic [7:0]    din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [3:0]    nib,
  output logic          nib_ok,
  output logic          empty,
  output logic [AW:0]   level,
`ifdef JT7759_NBUF_UFCNT_EN
  output logic [7:0]    ufcnt,
`endif
  output logic          uflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          half_q, half_d;
  logic [3:0]    nib_q, nib_d;
  logic          nib_ok_q, nib_ok_d;
  logic          uflow_q, uflow_d;
  logic          wr_s, pop_s, mem_we_s;
  logic [7:0]    rd_byte_s;
`ifdef JT7759_NBUF_UFCNT_EN
  logic [7:0]    ufcnt_q, ufcnt_d;
`endif

  assign din_ready = (level_q != FULL);
  assign empty     = (level_q == {(AW+1){1'b0}});
  assign level     = level_q;
  assign nib       = nib_q;
  assign nib_ok    = nib_ok_q;
  assign uflow     = uflow_q;
  assign rd_byte_s = mem_q[rp_q];
`ifdef JT7759_NBUF_UFCNT_EN
  assign ufcnt     = ufcnt_q;
`endif

  // Next-state: flush wins; otherwise independent write and nibble read, level nets both.
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    level_d  = level_q;
    half_d   = half_q;
    nib_d    = nib_q;
    nib_ok_d = 1'b0;
    uflow_d  = uflow_q;
    wr_s     = 1'b0;
    pop_s    = 1'b0;
    mem_we_s = 1'b0;
`ifdef JT7759_NBUF_UFCNT_EN
    ufcnt_d  = ufcnt_q;
`endif
    if (flush) begin
      wp_d    = {AW{1'b0}};
      rp_d    = {AW{1'b0}};
      level_d = {(AW+1){1'b0}};
      half_d  = 1'b0;
      nib_d   = 4'h0;
      uflow_d = 1'b0;
`ifdef JT7759_NBUF_UFCNT_EN
      ufcnt_d = 8'h00;
`endif
    end else begin
      wr_s     = din_valid && din_ready;
      mem_we_s = wr_s;
      if (wr_s) begin
        wp_d = wp_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wp_d = wp_q;
      end
      if (cen_dec) begin
        if (!empty) begin
          nib_d    = half_q ? rd_byte_s[3:0] : rd_byte_s[7:4];
          nib_ok_d = 1'b1;
          half_d   = ~half_q;
          pop_s    = half_q;
          if (half_q) begin
            rp_d = rp_q + {{(AW-1){1'b0}}, 1'b1};
          end else begin
            rp_d = rp_q;
          end
        end else begin
          // A byte written this same cycle is not readable yet: still a starve.
          uflow_d = 1'b1;
`ifdef JT7759_NBUF_UFCNT_EN
          if (ufcnt_q != 8'hFF) begin
            ufcnt_d = ufcnt_q + 8'h01;
          end else begin
            ufcnt_d = ufcnt_q;
          end
`endif
        end
      end else begin
        nib_ok_d = 1'b0;
      end
      level_d = level_q + {{AW{1'b0}}, wr_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q     <= {AW{1'b0}};
      rp_q     <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
      half_q   <= 1'b0;
      nib_q    <= 4'h0;
      nib_ok_q <= 1'b0;
      uflow_q  <= 1'b0;
`ifdef JT7759_NBUF_UFCNT_EN
      ufcnt_q  <= 8'h00;
`endif
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      level_q  <= level_d;
      half_q   <= half_d;
      nib_q    <= nib_d;
      nib_ok_q <= nib_ok_d;
      uflow_q  <= uflow_d;
`ifdef JT7759_NBUF_UFCNT_EN
      ufcnt_q  <= ufcnt_d;
`endif
    end
  end

  // Byte storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wp_q] <= din;
    end
  end

endmodule
